// File: rtl/ex_muldiv_pkg.sv
// Shared types for the RV32M multiply/divide unit: funct3 op codes, FSM states, op classifiers.
package ex_muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } muldiv_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_DONE
    } muldiv_state_e;

    // funct7 of OP-class M-extension instructions; decode lives in id.
    localparam logic [6:0] OP_FUNCT7_M = 7'b0000001;

    function automatic logic op_is_div(muldiv_op_e op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

    function automatic logic op_a_signed(muldiv_op_e op);
        return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    function automatic logic op_b_signed(muldiv_op_e op);
        return op inside {OP_MULH, OP_DIV, OP_REM};
    endfunction

endpackage

// File: rtl/ex_muldiv_if.sv
// EX-stage request/response bundle between the pipeline and ex_muldiv.
interface ex_muldiv_if #(parameter int unsigned XLEN = 32);

    logic            start_i;
    logic [2:0]      op_i;
    logic [XLEN-1:0] rs1_i;
    logic [XLEN-1:0] rs2_i;
    logic [4:0]      reg_waddr_i;
    logic            scour_i;
    logic            hold_req_o;
    logic            valid_o;
    logic [XLEN-1:0] result_o;
    logic [4:0]      reg_waddr_o;
    logic            reg_we_o;

    modport master (
        output start_i, op_i, rs1_i, rs2_i, reg_waddr_i, scour_i,
        input  hold_req_o, valid_o, result_o, reg_waddr_o, reg_we_o
    );

    modport slave (
        input  start_i, op_i, rs1_i, rs2_i, reg_waddr_i, scour_i,
        output hold_req_o, valid_o, result_o, reg_waddr_o, reg_we_o
    );

endinterface

// File: rtl/ex_muldiv_div_iter.sv
// One radix-2 restoring division step on unsigned magnitudes.
module ex_div_iter #(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] rem_i,
    input  logic [XLEN-1:0] quot_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN-1:0] rem_o,
    output logic [XLEN-1:0] quot_o
);

    logic [XLEN:0]   shl;
    logic [XLEN-1:0] diff;

    always_comb begin
        shl  = {rem_i, quot_i[XLEN-1]};
        diff = shl[XLEN-1:0] - divisor_i;
        if (shl >= {1'b0, divisor_i}) begin
            rem_o  = diff;
            quot_o = {quot_i[XLEN-2:0], 1'b1};
        end else begin
            rem_o  = shl[XLEN-1:0];
            quot_o = {quot_i[XLEN-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/ex_muldiv.sv
// RV32M iterative multiply/divide unit in EX; stalls the pipeline while busy.
// Optional build macro FAST_MUL_EN: multiplies complete in one cycle, divides stay iterative.
module ex_muldiv
    import ex_muldiv_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic         clk,
    input  logic         rst,
    ex_muldiv_if.slave   bus
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

    muldiv_state_e     state_q, state_d;
    muldiv_op_e        op_q, op_d, op_in;
    logic [XLEN-1:0]   a_q, a_d, b_q, b_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic              neg_q, neg_d, rneg_q, rneg_d;
    logic [4:0]        waddr_q, waddr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              sa, sb, div_zero, div_ovf;
    logic [XLEN-1:0]   ma, mb, rem_step, quot_step;
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_step, prod;
    logic [XLEN-1:0]   quot, rem, res;
    logic              hold;

    ex_div_iter #(.XLEN(XLEN)) u_div_iter (
        .rem_i     (acc_q[2*XLEN-1:XLEN]),
        .quot_i    (acc_q[XLEN-1:0]),
        .divisor_i (b_q),
        .rem_o     (rem_step),
        .quot_o    (quot_step)
    );

    assign op_in = muldiv_op_e'(bus.op_i);

    always_comb begin
        sa       = op_a_signed(op_in) & bus.rs1_i[XLEN-1];
        sb       = op_b_signed(op_in) & bus.rs2_i[XLEN-1];
        ma       = sa ? -bus.rs1_i : bus.rs1_i;
        mb       = sb ? -bus.rs2_i : bus.rs2_i;
        div_zero = op_is_div(op_in) && (bus.rs2_i == '0);
        div_ovf  = (op_in inside {OP_DIV, OP_REM}) && (bus.rs2_i == '1)
                   && (bus.rs1_i == {1'b1, {(XLEN-1){1'b0}}});
        // Shift-add: accumulate into the high half, shift the multiplier out of the low half.
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, a_q} : '0);
        mul_step = {mul_sum, acc_q[XLEN-1:1]};
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        waddr_d = waddr_q;
        cnt_d   = cnt_q;
        hold    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start_i) begin
                    hold    = 1'b1;
                    op_d    = op_in;
                    waddr_d = bus.reg_waddr_i;
                    a_d     = ma;
                    b_d     = mb;
                    neg_d   = sa ^ sb;
                    rneg_d  = sa;
                    cnt_d   = '0;
                    // Special cases are preloaded as {remainder, quotient} with signs cleared.
                    if (div_zero || div_ovf) begin
                        neg_d   = 1'b0;
                        rneg_d  = 1'b0;
                        acc_d   = div_zero ? {bus.rs1_i, {XLEN{1'b1}}}
                                           : {{XLEN{1'b0}}, bus.rs1_i};
                        state_d = ST_DONE;
                    end else if (op_is_div(op_in)) begin
                        acc_d   = {{XLEN{1'b0}}, ma};
                        state_d = ST_CALC;
                    end else begin
`ifdef FAST_MUL_EN
                        acc_d   = {{XLEN{1'b0}}, ma} * {{XLEN{1'b0}}, mb};
                        state_d = ST_DONE;
`else
                        acc_d   = {{XLEN{1'b0}}, mb};
                        state_d = ST_CALC;
`endif
                    end
                end
            end
            ST_CALC: begin
                hold  = 1'b1;
                acc_d = op_is_div(op_q) ? {rem_step, quot_step} : mul_step;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (bus.scour_i) begin
            state_d = ST_IDLE;
            hold    = 1'b0;
        end
    end

    always_comb begin
        prod = neg_q ? -acc_q : acc_q;
        quot = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem  = rneg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        unique case (op_q)
            OP_MUL:           res = prod[XLEN-1:0];
            OP_DIV, OP_DIVU:  res = quot;
            OP_REM, OP_REMU:  res = rem;
            default:          res = prod[2*XLEN-1:XLEN];
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= OP_MUL;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            waddr_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            waddr_q <= waddr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.hold_req_o  = hold;
    assign bus.valid_o     = (state_q == ST_DONE) && !bus.scour_i;
    assign bus.reg_we_o    = bus.valid_o;
    assign bus.result_o    = bus.valid_o ? res : '0;
    assign bus.reg_waddr_o = waddr_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: directed vector table, control corner sequences, random ops vs. arithmetic model.
module tb_ex_muldiv;

    localparam int LAT_IT = 33;
`ifdef FAST_MUL_EN
    localparam int LAT_MUL = 1;
`else
    localparam int LAT_MUL = 33;
`endif

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    ex_muldiv_if #(.XLEN(32)) bus ();

    ex_muldiv #(.XLEN(32), .CNT_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic void check(string name, logic [63:0] got, logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endfunction

    // Arithmetic reference: 64-bit products and SV integer division (truncates toward zero).
    function automatic logic [31:0] ref_muldiv(logic [2:0] op, logic [31:0] a, logic [31:0] b);
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        case (op)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                p = sa / sb; return p[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                p = sa % sb; return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_lat(logic [2:0] op, logic [31:0] a, logic [31:0] b);
        if (op >= 3'd4) begin
            if (b == 0) return 1;
            if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
            return LAT_IT;
        end
        return LAT_MUL;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Called on a negedge; returns on the negedge after the valid cycle.
    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
        int         cyc;
        int         holds;
        logic [4:0] wa;
        wa = 5'($urandom);
        bus.op_i        = op;
        bus.rs1_i       = a;
        bus.rs2_i       = b;
        bus.reg_waddr_i = wa;
        bus.start_i     = 1'b1;
        #1;
        holds = bus.hold_req_o ? 1 : 0;
        @(posedge clk);
        #1;
        bus.start_i     = 1'b0;
        bus.rs1_i       = $urandom;
        bus.rs2_i       = $urandom;
        bus.reg_waddr_i = 5'($urandom);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (!bus.valid_o && bus.hold_req_o) holds++;
        end while (!bus.valid_o && cyc < 100);
        check({name, " latency"}, 64'(cyc), 64'(exp_lat));
        check({name, " hold cycles"}, 64'(holds), 64'(exp_lat));
        check({name, " result"}, 64'(bus.result_o), 64'(exp_res));
        check({name, " waddr"}, 64'(bus.reg_waddr_o), 64'(wa));
        check({name, " we/hold in done"}, {62'd0, bus.reg_we_o, bus.hold_req_o}, 64'b10);
        @(negedge clk);
        check({name, " valid one cycle"}, 64'(bus.valid_o), 64'd0);
    endtask

    task automatic expect_quiet(input string name, input int cycles);
        int noisy;
        noisy = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (bus.valid_o || bus.hold_req_o) noisy++;
        end
        check(name, 64'(noisy), 64'd0);
    endtask

    vec_t vecs[15];

    initial begin
        vecs[0]  = '{"DIV 100/7",        3'd4, 32'd100,        32'd7,          32'd14,         LAT_IT};
        vecs[1]  = '{"REM 100/7",        3'd6, 32'd100,        32'd7,          32'd2,          LAT_IT};
        vecs[2]  = '{"DIV -7/2",         3'd4, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  LAT_IT};
        vecs[3]  = '{"REM -7/2",         3'd6, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  LAT_IT};
        vecs[4]  = '{"DIVU max/2",       3'd5, 32'hFFFF_FFFF,  32'd2,          32'h7FFF_FFFF,  LAT_IT};
        vecs[5]  = '{"DIVU 5/0",         3'd5, 32'd5,          32'd0,          32'hFFFF_FFFF,  1};
        vecs[6]  = '{"REMU 5/0",         3'd7, 32'd5,          32'd0,          32'd5,          1};
        vecs[7]  = '{"DIV -5/0",         3'd4, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF,  1};
        vecs[8]  = '{"REM -5/0",         3'd6, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB,  1};
        vecs[9]  = '{"DIV ovf",          3'd4, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1};
        vecs[10] = '{"REM ovf",          3'd6, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1};
        vecs[11] = '{"MULH min*min",     3'd1, 32'h8000_0000,  32'h8000_0000,  32'h4000_0000,  LAT_MUL};
        vecs[12] = '{"MULHU max*max",    3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  LAT_MUL};
        vecs[13] = '{"MULHSU -1*2",      3'd2, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFF,  LAT_MUL};
        vecs[14] = '{"MUL -1*2",         3'd0, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFE,  LAT_MUL};

        rst             = 1'b1;
        bus.start_i     = 1'b0;
        bus.op_i        = '0;
        bus.rs1_i       = '0;
        bus.rs2_i       = '0;
        bus.reg_waddr_i = '0;
        bus.scour_i     = 1'b0;
        #1;
        check("reset outputs",
              {bus.hold_req_o, bus.valid_o, bus.reg_we_o, bus.reg_waddr_o, bus.result_o}, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("idle after reset", {62'd0, bus.hold_req_o, bus.valid_o}, 64'd0);

        foreach (vecs[i])
            run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].lat);

        // start held high: DONE ignores it, IDLE restarts on the next cycle
        bus.op_i = 3'd5; bus.rs1_i = 32'd5; bus.rs2_i = 32'd0; bus.reg_waddr_i = 5'd3;
        bus.start_i = 1'b1;
        @(negedge clk);
        check("b2b first valid/hold", {62'd0, bus.valid_o, bus.hold_req_o}, 64'b10);
        @(negedge clk);
        check("b2b bubble valid/hold", {62'd0, bus.valid_o, bus.hold_req_o}, 64'b01);
        @(negedge clk);
        check("b2b second valid/hold", {62'd0, bus.valid_o, bus.hold_req_o}, 64'b10);
        bus.start_i = 1'b0;
        @(negedge clk);
        check("b2b drained", 64'(bus.valid_o), 64'd0);

        // flush mid-calculation
        bus.op_i = 3'd4; bus.rs1_i = 32'd1000; bus.rs2_i = 32'd3; bus.reg_waddr_i = 5'd9;
        bus.start_i = 1'b1;
        @(posedge clk);
        #1 bus.start_i = 1'b0;
        repeat (10) @(negedge clk);
        check("calc holds before flush", 64'(bus.hold_req_o), 64'd1);
        bus.scour_i = 1'b1;
        #1;
        check("flush drops hold/valid", {62'd0, bus.hold_req_o, bus.valid_o}, 64'd0);
        @(posedge clk);
        #1 bus.scour_i = 1'b0;
        expect_quiet("flush no result", 40);
        run_op("DIV after flush", 3'd4, 32'd1000, 32'd3, 32'd333, LAT_IT);

        // flush and start together: nothing starts
        bus.op_i = 3'd5; bus.rs1_i = 32'd7; bus.rs2_i = 32'd0;
        bus.start_i = 1'b1;
        bus.scour_i = 1'b1;
        #1;
        check("start+flush no hold", 64'(bus.hold_req_o), 64'd0);
        @(posedge clk);
        #1 begin bus.start_i = 1'b0; bus.scour_i = 1'b0; end
        expect_quiet("start+flush no result", 5);

        // async reset mid-calculation
        bus.op_i = 3'd6; bus.rs1_i = 32'd12345; bus.rs2_i = 32'd17; bus.reg_waddr_i = 5'h1F;
        bus.start_i = 1'b1;
        @(posedge clk);
        #1 bus.start_i = 1'b0;
        repeat (5) @(negedge clk);
        check("waddr before reset", 64'(bus.reg_waddr_o), 64'h1F);
        rst = 1'b1;
        #1;
        check("async reset outputs",
              {bus.hold_req_o, bus.valid_o, bus.reg_we_o, bus.reg_waddr_o, bus.result_o}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        expect_quiet("reset no result", 40);
        run_op("REM after reset", 3'd6, 32'd12345, 32'd17, 32'd3, LAT_IT);

        for (int n = 0; n < 40; n++) begin
            logic [2:0]  op;
            logic [31:0] a, b;
            op = 3'($urandom_range(0, 7));
            a  = pick_operand();
            b  = pick_operand();
            run_op($sformatf("rand%0d op%0d %h %h", n, op, a, b), op, a, b,
                   ref_muldiv(op, a, b), ref_lat(op, a, b));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
